// File: rtl/hdc_pkg.sv
// Shared hyperdimensional constants and serializer state encoding.
// DIM is also used by the inference compare path so both ends agree on length.
package hdc_pkg;

    localparam int DIM         = 128;
    localparam int MAX_SAMPLES = 15;
    localparam int CNT_W       = 4;
    localparam int IDX_W       = 8;

    typedef enum logic [1:0] {
        ACCUM,
        QUANT,
        SEND,
        DONE
    } tx_state_t;

endpackage

// File: rtl/bundle_counter.sv
// Per-dimension bundling counter.
// clr has priority over inc.
module bundle_counter #(
    parameter int W = hdc_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hv_bundle_tx.sv
// Bundles binary sample hypervectors, majority-quantizes them and
// streams the query hypervector out one bit per transfer, index 0 first.
module hv_bundle_tx #(
    parameter int DIM         = hdc_pkg::DIM,
    parameter int MAX_SAMPLES = hdc_pkg::MAX_SAMPLES,
    parameter int CNT_W       = hdc_pkg::CNT_W,
    parameter int IDX_W       = hdc_pkg::IDX_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sample_valid,
    input  logic [DIM-1:0] sample_in,
    input  logic           sample_last,
    output logic           sample_ready,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           tx_bit,
    output logic           tx_first,
    output logic           tx_last,
    output logic           done
);

    import hdc_pkg::*;

    tx_state_t        state;
    logic [CNT_W-1:0] n;
    logic [IDX_W-1:0] idx;
    logic [DIM-1:0]   q;
    logic [DIM-1:0]   qNext;
    logic [CNT_W-1:0] cnt [DIM];
    logic             accept;
    logic             xfer;
    logic             clrCnt;

    assign sample_ready = (state == ACCUM);
    assign accept       = sample_valid & sample_ready;
    assign tx_valid     = (state == SEND);
    assign xfer         = tx_valid & tx_ready;
    assign clrCnt       = (state == DONE);
    assign done         = (state == DONE);

    // q shifts right on each transfer, so q[0] is always bit q[idx].
    assign tx_bit   = tx_valid & q[0];
    assign tx_first = tx_valid && (idx == '0);
    assign tx_last  = tx_valid && (idx == IDX_W'(DIM - 1));

    for (genvar i = 0; i < DIM; i++) begin : gCnt
        bundle_counter #(.W(CNT_W)) uCnt (
            .clk  (clk),
            .reset(reset),
            .inc  (accept & sample_in[i]),
            .clr  (clrCnt),
            .cnt  (cnt[i])
        );
    end

    // Strict majority at CNT_W+1 bits; a tie quantizes to 0.
    always_comb begin
        qNext = '0;
        for (int i = 0; i < DIM; i++) begin
            qNext[i] = ({cnt[i], 1'b0} > {1'b0, n});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
            n     <= '0;
            idx   <= '0;
            q     <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        n <= n + CNT_W'(1);
                        if (sample_last ||
                            n == CNT_W'(MAX_SAMPLES - 1)) begin
                            state <= QUANT;
                        end
                    end
                end
                QUANT: begin
                    q     <= qNext;
                    idx   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        q   <= q >> 1;
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(DIM - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    n     <= '0;
                    idx   <= '0;
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_bundle_tx.sv
// Scoreboard bench for hv_bundle_tx: a reference bundling model pushes
// expected bits; a negedge monitor pops and compares each transfer.
module tb_hv_bundle_tx;

    import hdc_pkg::*;

    logic           clk = 0;
    logic           reset = 1;
    logic           sample_valid = 0;
    logic [DIM-1:0] sample_in = '0;
    logic           sample_last = 0;
    logic           sample_ready;
    logic           tx_valid;
    logic           tx_ready = 1;
    logic           tx_bit;
    logic           tx_first;
    logic           tx_last;
    logic           done;

    int   tests = 0;
    int   fails = 0;
    logic expQ[$];
    int   xferCnt = 0;
    int   cntm[DIM];
    int   nm = 0;
    logic stallPrev = 0;
    logic pBit, pFirst, pLast;
    logic toggle = 0;

    always #5 clk = ~clk;

    hv_bundle_tx dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .sample_last (sample_last),
        .sample_ready(sample_ready),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_bit      (tx_bit),
        .tx_first    (tx_first),
        .tx_last     (tx_last),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DIM; i++) cntm[i] = 0;
        nm = 0;
    endtask

    task automatic model_add(input logic [DIM-1:0] v, input logic last);
        for (int i = 0; i < DIM; i++) cntm[i] += int'(v[i]);
        nm++;
        if (last || nm == MAX_SAMPLES) begin
            for (int i = 0; i < DIM; i++) expQ.push_back(2 * cntm[i] > nm);
            model_clear();
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                if (expQ.size() == 0) begin
                    chk("xfer_extra", 1, 0);
                end else begin
                    chk("bit", {31'b0, tx_bit}, {31'b0, expQ.pop_front()});
                end
                chk("first", {31'b0, tx_first}, {31'b0, xferCnt == 0});
                chk("last", {31'b0, tx_last}, {31'b0, xferCnt == DIM - 1});
                xferCnt++;
            end
            if (stallPrev) begin
                chk("hold_valid", {31'b0, tx_valid}, 1);
                chk("hold_bit", {31'b0, tx_bit}, {31'b0, pBit});
                chk("hold_first", {31'b0, tx_first}, {31'b0, pFirst});
                chk("hold_last", {31'b0, tx_last}, {31'b0, pLast});
            end
            stallPrev = tx_valid && !tx_ready;
            pBit = tx_bit;
            pFirst = tx_first;
            pLast = tx_last;
        end
    end

    task automatic send(input logic [DIM-1:0] v, input logic last);
        bit ok = 0;
        sample_valid = 1;
        sample_in = v;
        sample_last = last;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sample_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        sample_valid = 0;
        sample_last = 0;
        model_add(v, last);
    endtask

    task automatic wait_done(input bit chkRdy, output int cyc,
                             output int firstV, output int vcnt);
        int pat[4] = '{1, 0, 0, 1};
        cyc = -1;
        firstV = -1;
        vcnt = 0;
        for (int c = 1; c < 2000; c++) begin
            @(negedge clk);
            if (chkRdy) chk("ready_busy", {31'b0, sample_ready}, 0);
            if (tx_valid && firstV < 0) firstV = c;
            if (tx_valid) vcnt++;
            if (done) begin
                cyc = c;
                break;
            end
            @(posedge clk);
            #1;
            if (toggle) tx_ready = pat[c % 4][0];
        end
        if (cyc < 0) chk("done_timeout", 0, 1);
        tx_ready = 1;
    endtask

    task automatic end_query(input string tag);
        chk({tag, "_xfers"}, xferCnt, DIM);
        chk({tag, "_qempty"}, expQ.size(), 0);
        xferCnt = 0;
    endtask

    initial begin
        int cyc, fv, vc;
        logic [DIM-1:0] v;
        model_clear();
        #23;
        chk("rst_valid", {31'b0, tx_valid}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_bit", {31'b0, tx_bit}, 0);
        chk("rst_first", {31'b0, tx_first}, 0);
        chk("rst_last", {31'b0, tx_last}, 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("rst_ready", {31'b0, sample_ready}, 1);

        // 1: majority of ones, timing
        send('1, 0);
        send('1, 0);
        send('0, 1);
        wait_done(0, cyc, fv, vc);
        chk("t1_done_cyc", cyc, DIM + 2);
        chk("t1_first_valid", fv, 2);
        chk("t1_valid_cycles", vc, DIM);
        end_query("t1");

        // 2: tie rule
        v = '0;
        v[3:0] = 4'hF;
        send(v, 0);
        v[3:0] = 4'h3;
        send(v, 1);
        wait_done(0, cyc, fv, vc);
        chk("t2_done_cyc", cyc, DIM + 2);
        end_query("t2");

        // 3: forced close after MAX_SAMPLES
        v = '0;
        v[5] = 1'b1;
        for (int k = 0; k < MAX_SAMPLES; k++) send(v, 0);
        @(negedge clk);
        chk("t3_ready_low", {31'b0, sample_ready}, 0);
        wait_done(0, cyc, fv, vc);
        end_query("t3");

        // 4: backpressure
        for (int k = 0; k < 3; k++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            send(v, k == 2);
        end
        toggle = 1;
        wait_done(0, cyc, fv, vc);
        toggle = 0;
        end_query("t4");

        // 5: reset abort at bit 40
        v = {$urandom, $urandom, $urandom, $urandom};
        send(v, 0);
        send(~v, 0);
        send(v, 1);
        cyc = -1;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (xferCnt >= 40) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) chk("t5_reach40", 0, 1);
        reset = 1;
        #1;
        chk("t5_valid", {31'b0, tx_valid}, 0);
        chk("t5_done", {31'b0, done}, 0);
        expQ.delete();
        xferCnt = 0;
        stallPrev = 0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
        v = {(DIM / 8){8'hAA}};
        send(v, 1);
        wait_done(0, cyc, fv, vc);
        chk("t5_done_cyc", cyc, DIM + 2);
        end_query("t5");

        // 6: back-to-back with sample_valid held
        v = {$urandom, $urandom, $urandom, $urandom};
        sample_valid = 1;
        sample_in = v;
        sample_last = 1;
        @(negedge clk);
        chk("t6_ready0", {31'b0, sample_ready}, 1);
        @(posedge clk);
        #1;
        model_add(v, 1);
        v = {$urandom, $urandom, $urandom, $urandom};
        sample_in = v;
        wait_done(1, cyc, fv, vc);
        chk("t6a_done_cyc", cyc, DIM + 2);
        end_query("t6a");
        model_add(v, 1);
        @(negedge clk);
        chk("t6_ready_after", {31'b0, sample_ready}, 1);
        @(posedge clk);
        #1;
        sample_valid = 0;
        sample_last = 0;
        wait_done(0, cyc, fv, vc);
        chk("t6b_done_cyc", cyc, DIM + 2);
        end_query("t6b");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
